// File: rtl/apb_uart_master_if.sv
// Command/response stream plus APB requester bus for apb_uart_master.
// master = the requester block, slave = command source / response sink / APB completer side.
interface apb_uart_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  rsp_timeout;
  logic                  busy;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_uart_master.sv
// APB requester for the UART register block: buffers commands in a small FIFO,
// runs SETUP/ACCESS transfers with a PREADY watchdog and returns one response per command.
module apb_uart_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_uart_master_if.master bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  cmd_t                  mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;
  state_e                state_q;
  logic [CW-1:0]         wait_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q, rsp_error_q, rsp_timeout_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic full, empty, push, pop, slot_free, start, chain;
  cmd_t head;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = bus.cmd_valid && !full;
  assign head      = mem_q[rd_ptr_q];
  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign start     = (state_q == IDLE) && !empty && slot_free;
  // Chaining straight into SETUP relies on the consumer taking the response
  // about to be produced; otherwise fall back to IDLE and wait for the slot.
  assign chain     = (state_q == ACCESS) && bus.PREADY && !empty && bus.rsp_ready;
  assign pop       = start || chain;

  always_ff @(posedge PCLK) begin
    if (push) mem_q[wr_ptr_q] <= '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= head.write;
            paddr_q  <= head.addr;
            pwdata_q <= head.wdata;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          wait_q    <= '0;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
            rsp_error_q   <= bus.PSLVERR;
            rsp_timeout_q <= 1'b0;
            penable_q     <= 1'b0;
            if (chain) begin
              state_q  <= SETUP;
              pwrite_q <= head.write;
              paddr_q  <= head.addr;
              pwdata_q <= head.wdata;
            end else begin
              state_q  <= IDLE;
              psel_q   <= 1'b0;
              pwrite_q <= 1'b0;
              paddr_q  <= '0;
              pwdata_q <= '0;
            end
          end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.busy        = !empty || (state_q != IDLE) || rsp_valid_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_uart_master.sv
// Directed bench for apb_uart_master: phasing, back-to-back, FIFO full, wait states,
// PSLVERR, watchdog abort and mid-transfer reset.
module tb_apb_uart_master;
  logic        clk;
  logic        rst;
  logic        auto_rd;
  logic [31:0] prdata_v;
  int          checks = 0;
  int          errors = 0;

  apb_uart_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_uart_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completer read data: either a fixed value or address + 0x100.
  always_comb bus.PRDATA = auto_rd ? (bus.PADDR + 32'h100) : prdata_v;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  // Single transfer from an idle, empty block; PREADY low for 'waits' ACCESS cycles.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic slverr, input int waits,
                      input logic [31:0] exp_rd, input logic exp_err);
    auto_rd     = 1'b0;
    prdata_v    = rdata;
    bus.PSLVERR = slverr;
    bus.PREADY  = 1'b0;
    bus.rsp_ready = 1'b0;
    push(wr, addr, wdata);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk1({tag, "_idle_psel"}, bus.PSEL, 1'b0);
    chk1({tag, "_busy"}, bus.busy, 1'b1);
    @(negedge clk);
    chk1({tag, "_setup_psel"}, bus.PSEL, 1'b1);
    chk1({tag, "_setup_pen"}, bus.PENABLE, 1'b0);
    chk32({tag, "_paddr"}, bus.PADDR, addr);
    chk1({tag, "_pwrite"}, bus.PWRITE, wr);
    chk32({tag, "_pwdata"}, bus.PWDATA, wdata);
    for (int j = 1; j <= waits + 1; j++) begin
      @(negedge clk);
      chk1({tag, "_acc_pen"}, bus.PENABLE, 1'b1);
      chk32({tag, "_acc_paddr"}, bus.PADDR, addr);
      chk32({tag, "_acc_pwdata"}, bus.PWDATA, wdata);
      chk1({tag, "_acc_rspv"}, bus.rsp_valid, 1'b0);
      bus.PREADY = (j == waits + 1);
    end
    @(negedge clk);
    bus.PREADY = 1'b0;
    chk1({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    chk32({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rd);
    chk1({tag, "_rsp_error"}, bus.rsp_error, exp_err);
    chk1({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    chk1({tag, "_end_psel"}, bus.PSEL, 1'b0);
    @(negedge clk);
    chk1({tag, "_rsp_held"}, bus.rsp_valid, 1'b1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.PSLVERR   = 1'b0;
    chk1({tag, "_rsp_clr"}, bus.rsp_valid, 1'b0);
    chk1({tag, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] exp_rd, input logic exp_err, input logic exp_to);
    int t = 0;
    while (!bus.rsp_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk1({tag, "_valid"}, bus.rsp_valid, 1'b1);
    chk32({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
    chk1({tag, "_error"}, bus.rsp_error, exp_err);
    chk1({tag, "_timeout"}, bus.rsp_timeout, exp_to);
    @(negedge clk);
  endtask

  initial begin
    logic ok;
    rst = 1'b1;
    auto_rd = 1'b0;
    prdata_v = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_psel", bus.PSEL, 1'b0);
    chk1("rst_penable", bus.PENABLE, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk32("rst_paddr", bus.PADDR, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Baud write then read-back.
    xfer("baud_wr", 1'b1, 32'h0000_0000, 32'h0000_2580, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    xfer("baud_rd", 1'b0, 32'h0000_0000, 32'h0, 32'h0000_2580, 1'b0, 0, 32'h0000_2580, 1'b0);
    // Three PREADY-low cycles on a read.
    xfer("wait3", 1'b0, 32'h0000_0008, 32'h0, 32'h0000_00A5, 1'b0, 3, 32'h0000_00A5, 1'b0);
    // Completer error on a write.
    xfer("slverr", 1'b1, 32'h0000_000C, 32'h0000_0003, 32'h0, 1'b1, 0, 32'h0, 1'b1);

    // Back-to-back: four reads pushed on consecutive cycles, consumer always ready.
    auto_rd = 1'b1;
    bus.PREADY = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 32'(4 * (i + 1)), 32'h0);
      @(negedge clk);
      chk1("b2b_cmd_ready", bus.cmd_ready, 1'b1);
      if (i < 3) chk1("b2b_early_rspv", bus.rsp_valid, 1'b0);
    end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk1("b2b_rsp_pattern", bus.rsp_valid, (k % 2) == 0);
      if ((k % 2) == 0) chk32("b2b_rdata", bus.rsp_rdata, 32'h104 + 32'(4 * (k / 2)));
      @(negedge clk);
    end
    chk1("b2b_done_busy", bus.busy, 1'b0);

    // Fill the FIFO while the response slot is blocked.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 32'h20 + 32'(4 * i), 32'h0);
      @(negedge clk);
      if (i == 3) chk1("fill_not_full", bus.cmd_ready, 1'b1);
    end
    bus.cmd_valid = 1'b0;
    chk1("fill_full", bus.cmd_ready, 1'b0);
    chk1("fill_busy", bus.busy, 1'b1);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_rsp("fill_drain", 32'h120 + 32'(4 * i), 1'b0, 1'b0);
    chk1("fill_empty_ready", bus.cmd_ready, 1'b1);

    // Watchdog: PREADY stuck low, second command must still complete.
    bus.PREADY = 1'b0;
    push(1'b0, 32'h14, 32'h0);
    @(negedge clk);
    push(1'b0, 32'h18, 32'h0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk1("to_acc_entry", bus.PENABLE, 1'b1);
    chk1("to_acc_rspv", bus.rsp_valid, 1'b0);
    ok = 1'b1;
    for (int j = 2; j <= 16; j++) begin
      @(negedge clk);
      if (!(bus.PENABLE === 1'b1 && bus.rsp_valid === 1'b0 && bus.PADDR === 32'h14)) ok = 1'b0;
    end
    chk1("to_hold_16", ok, 1'b1);
    @(negedge clk);
    chk1("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk1("to_rsp_error", bus.rsp_error, 1'b1);
    chk1("to_rsp_timeout", bus.rsp_timeout, 1'b1);
    chk32("to_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("to_psel_drop", bus.PSEL, 1'b0);
    bus.PREADY = 1'b1;
    @(negedge clk);
    wait_rsp("to_next", 32'h118, 1'b0, 1'b0);

    // Reset in the second ACCESS cycle with two commands queued.
    bus.PREADY = 1'b0;
    bus.rsp_ready = 1'b0;
    push(1'b0, 32'h40, 32'h0);
    @(negedge clk);
    push(1'b0, 32'h44, 32'h0);
    @(negedge clk);
    push(1'b0, 32'h48, 32'h0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk1("mr_pre_pen", bus.PENABLE, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mr_psel", bus.PSEL, 1'b0);
    chk1("mr_penable", bus.PENABLE, 1'b0);
    chk1("mr_busy", bus.busy, 1'b0);
    chk1("mr_cmd_ready", bus.cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.PREADY = 1'b1;
    bus.rsp_ready = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(bus.PSEL === 1'b0 && bus.rsp_valid === 1'b0 && bus.busy === 1'b0)) ok = 1'b0;
    end
    chk1("mr_quiet", ok, 1'b1);
    chk1("mr_cmd_ready_after", bus.cmd_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_uart_master.md
# apb_uart_master

APB requester that drives the UART register interface from a simple command/response stream. It turns buffered write/read commands into APB SETUP/ACCESS transfers, waits for PREADY, and returns read data and error status. It sits between the test/processor-side command source and the APB UART slave, covering the baud, frame, parity, stop-bits, TX and RX addresses. It includes a small command FIFO and a PREADY timeout watchdog.

## Interface
- DATA_WIDTH, 32, width of PWDATA/PRDATA and command/response data
- ADDR_WIDTH, 32, width of PADDR and command address
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables the timeout
- PCLK  in  1  single clock; all state on rising edge
- PRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target register address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_WIDTH  captured PRDATA (0 for writes and timeouts)
- rsp_error  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer ended by the watchdog
- busy  out  1  FIFO non-empty, transfer in flight, or rsp_valid set
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1

## Operation
- Command FIFO:
  - A command is accepted on cmd_valid && cmd_ready and written at that edge.
  - cmd_ready = !full. A simultaneous push and pop while full is not allowed, because cmd_ready is low.
  - A simultaneous push and pop at any other fill level leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE → SETUP when the FIFO is non-empty and the response slot is free. The slot is free when rsp_valid = 0, or rsp_valid && rsp_ready in the same cycle.
  - On entering SETUP, the head entry is popped into the PADDR/PWRITE/PWDATA registers.
- SETUP (PSEL = 1, PENABLE = 0) → ACCESS unconditionally after one cycle.
- ACCESS (PSEL = 1, PENABLE = 1):
  - PADDR/PWRITE/PWDATA are held stable.
  - PREADY is sampled each cycle.
  - When PREADY = 1, the transfer completes:
    - rsp_rdata ← PWRITE ? 0 : PRDATA
    - rsp_error ← PSLVERR
    - rsp_timeout ← 0
    - rsp_valid ← 1
  - Next state after completion is SETUP if the FIFO is non-empty (the slot is freed by the same-cycle completion only if consumed, so completion goes to IDLE whenever rsp_valid would remain set and block the next transfer); otherwise IDLE.
- Watchdog:
  - wait_cnt clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - If TIMEOUT ≠ 0 and wait_cnt reaches TIMEOUT − 1 with PREADY still 0, the transfer is aborted:
    - PSEL/PENABLE drop next cycle.
    - rsp_valid = 1, rsp_error = 1, rsp_timeout = 1, rsp_rdata = 0.
    - FSM goes to IDLE.
- PSLVERR is ignored unless PREADY = 1 in ACCESS.
- Response: rsp_* are held until rsp_valid && rsp_ready, then rsp_valid clears next edge. rsp_rdata/rsp_error/rsp_timeout keep their last values.
- In IDLE, PSEL = PENABLE = PWRITE = 0, and PADDR/PWDATA = 0.

## Timing
- Reset (async assert, synchronous-to-PCLK release):
  - FSM goes to IDLE and the FIFO is flushed.
  - All outputs are 0, including rsp_valid, PSEL, PENABLE and busy. cmd_ready = 1.
- Reset mid-transfer: PSEL/PENABLE drop immediately and the in-flight command is lost with no response.
- Zero-wait transfer:
  - Command accepted at edge N.
  - SETUP in cycle N+1, ACCESS in cycle N+2 with PREADY = 1.
  - rsp_valid high from edge N+3.
- Each PREADY-low cycle adds one cycle of latency.
- Back-to-back: with rsp_ready held high, the next SETUP immediately follows ACCESS, giving 2 cycles per zero-wait transfer.
- Timeout latency with TIMEOUT = T: rsp_valid rises T cycles after ACCESS entry.

## Test plan
- Write 0x2580 to the baud address, then read it:
  - Two transfers with correct SETUP/ACCESS phasing.
  - The write response has rsp_rdata = 0, error = 0.
  - The read response has rsp_rdata = 0x2580.
- Push 4 commands in consecutive cycles with zero-wait PREADY and rsp_ready = 1:
  - cmd_ready low only when full.
  - Responses arrive in order, one every 2 cycles.
- Slave holds PREADY low for 3 ACCESS cycles on a read returning 0x0000_00A5:
  - PADDR/PWDATA stable throughout.
  - rsp_valid 4 cycles after ACCESS entry.
  - rsp_rdata = 0xA5.
- PREADY = 1 with PSLVERR = 1 on a write: rsp_error = 1, rsp_timeout = 0.
- TIMEOUT = 16, PREADY stuck low:
  - Abort after 16 ACCESS cycles with rsp_error = rsp_timeout = 1, rsp_rdata = 0.
  - The next queued command proceeds normally.
- Assert PRESET in the second ACCESS cycle with 2 commands queued:
  - PSEL = PENABLE = 0 immediately; the FIFO is empty and no response appears.
  - cmd_ready = 1 after reset release.
